// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared predictor state encoding and constants
package branch_target_buffer_pkg;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    STRONG_TAKEN     = 2'b10,
    WEAK_TAKEN       = 2'b11
  } btb_state_e;

  localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and execute training bundle
interface branch_target_buffer_if;
  logic [31:0] fetch_pc;
  logic        btb_hit;
  logic        predicted_taken;
  logic [31:0] predicted_target;
  logic        update_btb;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;

  modport master (
    output fetch_pc, update_btb, ex_pc, ex_target, ex_taken,
    input  btb_hit, predicted_taken, predicted_target
  );

  modport slave (
    input  fetch_pc, update_btb, ex_pc, ex_target, ex_taken,
    output btb_hit, predicted_taken, predicted_target
  );
endinterface

// File: rtl/btb_sat_counter.sv
// rtl/btb_sat_counter.sv - next-state function of the 2-bit taken/not-taken counter
module btb_sat_counter
  import branch_target_buffer_pkg::*;
(
  input  btb_state_e state,
  input  logic       taken,
  output btb_state_e next_state
);

  always_comb begin
    next_state = state;
    unique case (state)
      STRONG_NOT_TAKEN: next_state = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   next_state = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       next_state = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
      STRONG_TAKEN:     next_state = taken ? STRONG_TAKEN   : WEAK_TAKEN;
      default:          next_state = state;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with per-entry 2-bit counters
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = $clog2(ENTRIES),
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_target_buffer_if.slave  bus
);

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  btb_state_e          state_q  [ENTRIES];
  btb_state_e          state_d  [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit, u_hit;
  btb_state_e            u_next_state;
  logic                  unused_pc_bits;

  assign f_idx = bus.fetch_pc[INDEX_BITS+1:2];
  assign f_tag = bus.fetch_pc[31:INDEX_BITS+2];
  assign u_idx = bus.ex_pc[INDEX_BITS+1:2];
  assign u_tag = bus.ex_pc[31:INDEX_BITS+2];
  assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.ex_pc[1:0]};

  // Lookup reads registered storage only, so a same-cycle update is seen next cycle.
  always_comb begin
    f_hit                = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    bus.btb_hit          = f_hit;
    bus.predicted_taken  = f_hit && state_q[f_idx][1];
    bus.predicted_target = f_hit ? target_q[f_idx] : ZERO_32BIT;
  end

  btb_sat_counter u_sat_counter (
    .state      (state_q[u_idx]),
    .taken      (bus.ex_taken),
    .next_state (u_next_state)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    state_d  = state_q;
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    if (bus.update_btb) begin
      if (u_hit) begin
        state_d[u_idx] = u_next_state;
        if (bus.ex_taken) begin
          target_d[u_idx] = bus.ex_target;
        end
      end else if (bus.ex_taken) begin
        // Taken miss claims the slot outright, evicting any aliasing occupant.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bus.ex_target;
        state_d[u_idx]  = WEAK_TAKEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: ZERO_32BIT};
      state_q  <= '{default: WEAK_NOT_TAKEN};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed and random checks of branch_target_buffer
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_target_buffer_if bus ();

  branch_target_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: confidence 0..3, predict taken at 2 or above.
  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_conf   [16];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_conf[i]   = 1;
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (taken) begin
        m_conf[i]   = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
        m_target[i] = tgt;
      end else begin
        m_conf[i] = (m_conf[i] > 0) ? m_conf[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(pc);
      m_target[i] = tgt;
      m_conf[i]   = 2;
    end
  endtask

  task automatic check_model(input string tag);
    int          i;
    bit          e_hit, e_taken;
    logic [31:0] e_target;
    i        = idx_of(bus.fetch_pc);
    e_hit    = m_valid[i] && (m_tag[i] == tag_of(bus.fetch_pc));
    e_taken  = e_hit && (m_conf[i] >= 2);
    e_target = e_hit ? m_target[i] : 32'h0;
    n_checks++;
    assert (bus.btb_hit === e_hit) else begin
      n_fail++;
      $error("FAIL %s btb_hit pc=%h: got %b expected %b", tag, bus.fetch_pc, bus.btb_hit, e_hit);
    end
    n_checks++;
    assert (bus.predicted_taken === e_taken) else begin
      n_fail++;
      $error("FAIL %s predicted_taken pc=%h: got %b expected %b", tag, bus.fetch_pc, bus.predicted_taken, e_taken);
    end
    n_checks++;
    assert (bus.predicted_target === e_target) else begin
      n_fail++;
      $error("FAIL %s predicted_target pc=%h: got %h expected %h", tag, bus.fetch_pc, bus.predicted_target, e_target);
    end
  endtask

  // One clock: drive inputs, check pre-edge lookup, then advance model with the edge.
  task automatic drive(input logic [31:0] fpc, input bit upd, input logic [31:0] epc,
                       input logic [31:0] etgt, input bit etaken, input bit do_rst, input string tag);
    rst            = do_rst;
    bus.fetch_pc   = fpc;
    bus.update_btb = upd;
    bus.ex_pc      = epc;
    bus.ex_target  = etgt;
    bus.ex_taken   = etaken;
    #1;
    if (!do_rst) check_model(tag);
    @(posedge clk);
    if (do_rst) model_reset();
    else if (upd) model_update(epc, etgt, etaken);
    #1;
  endtask

  task automatic update(input logic [31:0] epc, input logic [31:0] etgt, input bit etaken);
    drive(32'h0, 1'b1, epc, etgt, etaken, 1'b0, "upd");
  endtask

  task automatic probe(input logic [31:0] fpc, input string tag, input bit e_hit,
                       input bit e_taken, input logic [31:0] e_target);
    rst            = 1'b0;
    bus.fetch_pc   = fpc;
    bus.update_btb = 1'b0;
    #1;
    n_checks++;
    assert (bus.btb_hit === e_hit) else begin
      n_fail++;
      $error("FAIL %s hit: got %b expected %b", tag, bus.btb_hit, e_hit);
    end
    n_checks++;
    assert (bus.predicted_taken === e_taken) else begin
      n_fail++;
      $error("FAIL %s taken: got %b expected %b", tag, bus.predicted_taken, e_taken);
    end
    n_checks++;
    assert (bus.predicted_target === e_target) else begin
      n_fail++;
      $error("FAIL %s target: got %h expected %h", tag, bus.predicted_target, e_target);
    end
    check_model(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fpc, epc;
    model_reset();
    bus.fetch_pc   = '0;
    bus.update_btb = 1'b0;
    bus.ex_pc      = '0;
    bus.ex_target  = '0;
    bus.ex_taken   = 1'b0;

    drive(32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "rst0");
    drive(32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "rst1");
    probe(32'h40, "reset_40", 1'b0, 1'b0, 32'h0);
    probe(32'hFFFF_FFFC, "reset_top", 1'b0, 1'b0, 32'h0);

    update(32'h40, 32'h100, 1'b1);
    probe(32'h40, "alloc_wt", 1'b1, 1'b1, 32'h100);

    update(32'h40, 32'h100, 1'b1);
    probe(32'h40, "walk_st", 1'b1, 1'b1, 32'h100);
    update(32'h40, 32'h999, 1'b0);
    probe(32'h40, "walk_nt1", 1'b1, 1'b1, 32'h100);
    update(32'h40, 32'h999, 1'b0);
    probe(32'h40, "walk_nt2", 1'b1, 1'b0, 32'h100);
    update(32'h40, 32'h999, 1'b0);
    probe(32'h40, "walk_nt3", 1'b1, 1'b0, 32'h100);
    update(32'h40, 32'h100, 1'b1);
    probe(32'h41, "walk_t1", 1'b1, 1'b0, 32'h100);
    update(32'h43, 32'h100, 1'b1);
    probe(32'h42, "walk_t2", 1'b1, 1'b1, 32'h100);

    update(32'h80, 32'h200, 1'b1);
    probe(32'h40, "alias_old", 1'b0, 1'b0, 32'h0);
    probe(32'h80, "alias_new", 1'b1, 1'b1, 32'h200);

    update(32'h10, 32'h400, 1'b0);
    probe(32'h10, "nt_miss", 1'b0, 1'b0, 32'h0);

    drive(32'h40, 1'b1, 32'h40, 32'h300, 1'b1, 1'b0, "collide_pre");
    probe(32'h40, "collide_post", 1'b1, 1'b1, 32'h300);

    drive(32'h80, 1'b1, 32'h80, 32'h500, 1'b1, 1'b1, "rst_upd");
    probe(32'h80, "rst_prio", 1'b0, 1'b0, 32'h0);
    probe(32'h40, "rst_clear", 1'b0, 1'b0, 32'h0);

    for (int n = 0; n < 600; n++) begin
      fpc = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      epc = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) epc = epc | 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) fpc = epc;
      drive(fpc, ($urandom_range(0, 3) != 0), epc, $urandom(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 79) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-side branch predictor: a direct-mapped BTB with a 2-bit saturating counter per entry.
- Each cycle it looks up the fetch PC and returns predicted_taken and predicted_target to the fetch stage.
- It is trained by the resolution outputs of the execute stage: update_btb, resolved PC, calc_jump_addr and the actual outcome.
- It is the producer of the execute stage's predictedTaken input.

Parameters:
- ENTRIES, 16: number of BTB entries; must be a power of two, minimum 2.
- INDEX_BITS, 4: log2(ENTRIES); entry index is pc[INDEX_BITS+1:2].
- TAG_BITS, 26: 30-INDEX_BITS; tag is pc[31:INDEX_BITS+2].

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- fetch_pc  input  32  PC being fetched this cycle.
- btb_hit  output  1  fetch_pc matches a valid entry.
- predicted_taken  output  1  prediction to fetch; piped to execute as predictedTaken.
- predicted_target  output  32  target to load into the PC when predicted_taken=1.
- update_btb  input  1  execute resolved a branch or jump this cycle.
- ex_pc  input  32  PC of the resolved instruction.
- ex_target  input  32  computed target (calc_jump_addr).
- ex_taken  input  1  actual outcome: 1 = taken (jump_en path taken).

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (32), state (2). Storage is flops, not SRAM.
- State encoding (shared defines):
  - STRONG_NOT_TAKEN = 00
  - WEAK_NOT_TAKEN = 01
  - STRONG_TAKEN = 10
  - WEAK_TAKEN = 11
  - Predict taken iff state[1]=1.
- Lookup is combinational, zero latency:
  - btb_hit = valid[idx] & (tag[idx] == fetch_pc tag field).
  - predicted_taken = btb_hit & state[idx][1].
  - predicted_target = target[idx] when btb_hit, else ZERO_32BIT.
- Update is registered; it takes effect on the clk edge where update_btb=1. Index and tag come from ex_pc.
- Counter FSM on a hit, with ex_taken=1:
  - SNT→WNT, WNT→WT, WT→ST, ST→ST.
  - target ← ex_target.
- Counter FSM on a hit, with ex_taken=0:
  - ST→WT, WT→WNT, WNT→SNT, SNT→SNT.
  - target unchanged.
- Miss with ex_taken=1: allocate the entry, overwriting any occupant. valid←1, tag←ex_pc tag, target←ex_target, state←WEAK_TAKEN.
- Miss with ex_taken=0: no allocation; storage unchanged.
- update_btb=0: storage unchanged.
- Read/write collision (fetch_pc and ex_pc map to the same index in the same cycle): lookup returns pre-update contents. New contents are visible the next cycle. No bypass.
- Reset: on any edge with rst=1:
  - all valid←0, all state←WEAK_NOT_TAKEN, tag/target←0.
  - rst has priority over a simultaneous update_btb.
  - Outputs are 0 in the cycle after reset, for any fetch_pc.
- ex_pc[1:0] and fetch_pc[1:0] are ignored.
- Aliasing: two PCs with the same index and different tag evict each other. No replacement policy beyond overwrite.
- No X propagation: outputs are fully defined for any fetch_pc once reset has been applied.

Decomposition:
- Shared defines header holds: STRONG_NOT_TAKEN, WEAK_NOT_TAKEN, STRONG_TAKEN, WEAK_TAKEN and ZERO_32BIT. These are the same definitions already used by the execute stage.
- One sub-module, btb_sat_counter: combinational next-state function, inputs state[1:0] and taken, output next_state[1:0]. It is instantiated once on the update path, at the update index.
- Storage arrays, index/tag split and lookup remain in branch_target_buffer.

Test Plan:
1. Reset with rst=1 for 2 cycles, then fetch_pc=0x00000040 → btb_hit=0, predicted_taken=0, predicted_target=0x00000000.
2. Cold taken allocation: update_btb=1, ex_pc=0x00000040, ex_target=0x00000100, ex_taken=1; next cycle fetch_pc=0x00000040 → btb_hit=1, predicted_taken=1 (WEAK_TAKEN), predicted_target=0x00000100.
3. Counter walk on ex_pc=0x40:
   - one more taken update → STRONG_TAKEN;
   - then three not-taken updates → after the first, predicted_taken=1 (WT); after the second, 0 (WNT); after the third, 0 (SNT);
   - two taken updates → 0 then 1.
4. Alias eviction: entry for 0x00000040 present; taken update ex_pc=0x00000080 (ENTRIES=16, same index 0, different tag), ex_target=0x00000200 → fetch 0x00000040 gives btb_hit=0; fetch 0x00000080 gives hit, target 0x00000200.
5. Not-taken miss: update_btb=1, ex_pc=0x00000010, ex_taken=0 → fetch 0x00000010 still gives btb_hit=0.
6. Collision and reset priority:
   - fetch_pc=ex_pc=0x00000040 with a taken update in the same cycle → outputs show the old state that cycle and the updated state the next.
   - rst=1 together with update_btb=1 → entry invalid afterwards.
